// File: rtl/fpnew_pipe_elastic.sv
// Elastic pipeline of NumStages register stages with flush and tag-selective kill.
// RegReady=0 collapses bubbles; RegReady=1 uses main+skid pairs so in_ready_o comes from a flop.
module fpnew_pipe_elastic #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned TagWidth  = 4,
    parameter int unsigned NumStages = 2,
    parameter int unsigned RegReady  = 0,
    localparam int unsigned Cap  = NumStages * (1 + RegReady),
    localparam int unsigned OccW = (Cap == 0) ? 1 : $clog2(Cap + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] data_i,
    input  logic [TagWidth-1:0]  tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    input  logic                 kill_i,
    input  logic [TagWidth-1:0]  kill_tag_i,
    output logic [DataWidth-1:0] data_o,
    output logic [TagWidth-1:0]  tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OccW-1:0]      occupancy_o,
    output logic                 busy_o
);

    if (NumStages == 0) begin : g_bypass
        assign data_o      = data_i;
        assign tag_o       = tag_i;
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign occupancy_o = '0;
        assign busy_o      = in_valid_i;
        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_ni, flush_i, kill_i, kill_tag_i};
    end else if (RegReady == 0) begin : g_collapse
        logic [NumStages-1:0] main_v, rdy, up_v, up_hit;
        logic [DataWidth-1:0] main_d [NumStages];
        logic [TagWidth-1:0]  main_t [NumStages];
        logic [DataWidth-1:0] up_d   [NumStages];
        logic [TagWidth-1:0]  up_t   [NumStages];
        logic                 full;

        // A stage is ready unless it and every stage after it are full while the sink stalls.
        always_comb begin
            // NOTE: every always_comb output gets a default first so no latch can be inferred.
            rdy     = '0;
            full    = 1'b1;
            up_v[0] = in_valid_i;
            up_d[0] = data_i;
            up_t[0] = tag_i;
            for (int k = NumStages - 1; k >= 0; k--) begin
                full   = full && main_v[k];
                rdy[k] = out_ready_i || !full;
            end
            for (int k = 1; k < NumStages; k++) begin
                up_v[k] = main_v[k-1];
                up_d[k] = main_d[k-1];
                up_t[k] = main_t[k-1];
            end
            for (int k = 0; k < NumStages; k++) begin
                up_hit[k] = kill_i && (up_t[k] == kill_tag_i);
            end
        end

        // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
        always_ff @(posedge clk_i) begin
            for (int k = 0; k < NumStages; k++) begin
                if (!rst_ni || flush_i)  main_v[k] <= 1'b0;
                else if (rdy[k])         main_v[k] <= up_v[k] && !up_hit[k];
                else                     main_v[k] <= main_v[k] && !(kill_i && main_t[k] == kill_tag_i);
            end
        end

        // NOTE: payload registers are deliberately unreset; only valid bits qualify them.
        always_ff @(posedge clk_i) begin
            for (int k = 0; k < NumStages; k++) begin
                if (up_v[k] && rdy[k] && !flush_i) begin
                    main_d[k] <= up_d[k];
                    main_t[k] <= up_t[k];
                end
            end
        end

        assign in_ready_o  = rdy[0];
        assign out_valid_o = main_v[NumStages-1];
        assign data_o      = main_d[NumStages-1];
        assign tag_o       = main_t[NumStages-1];
        assign occupancy_o = OccW'($countones(main_v));
        assign busy_o      = in_valid_i || (|main_v);
    end else begin : g_skid
        logic [NumStages-1:0] main_v, skid_v, out_v, up_v, dn_rdy;
        logic [NumStages-1:0] km, ks, ki, mv_n, sv_n, m_ld, s_ld;
        logic [DataWidth-1:0] main_d [NumStages];
        logic [DataWidth-1:0] skid_d [NumStages];
        logic [TagWidth-1:0]  main_t [NumStages];
        logic [TagWidth-1:0]  skid_t [NumStages];
        logic [DataWidth-1:0] out_d  [NumStages];
        logic [TagWidth-1:0]  out_t  [NumStages];
        logic [DataWidth-1:0] up_d   [NumStages];
        logic [TagWidth-1:0]  up_t   [NumStages];

        // Each stage is a two-entry queue: main is older than skid, survivors are compacted toward main.
        always_comb begin
            for (int k = 0; k < NumStages; k++) begin
                out_v[k]  = main_v[k] || skid_v[k];
                out_d[k]  = main_v[k] ? main_d[k] : skid_d[k];
                out_t[k]  = main_v[k] ? main_t[k] : skid_t[k];
                dn_rdy[k] = (k == NumStages - 1) ? out_ready_i : !skid_v[(k + 1) % NumStages];
            end
            up_v[0] = in_valid_i;
            up_d[0] = data_i;
            up_t[0] = tag_i;
            for (int k = 1; k < NumStages; k++) begin
                up_v[k] = out_v[k-1];
                up_d[k] = out_d[k-1];
                up_t[k] = out_t[k-1];
            end
            for (int k = 0; k < NumStages; k++) begin
                km[k]   = main_v[k] && !(out_v[k] && dn_rdy[k])
                          && !(kill_i && main_t[k] == kill_tag_i);
                ks[k]   = skid_v[k] && !(out_v[k] && dn_rdy[k] && !main_v[k])
                          && !(kill_i && skid_t[k] == kill_tag_i);
                ki[k]   = up_v[k] && !skid_v[k] && !(kill_i && up_t[k] == kill_tag_i);
                mv_n[k] = km[k] || ks[k] || ki[k];
                sv_n[k] = km[k] ? (ks[k] || ki[k]) : (ks[k] && ki[k]);
                m_ld[k] = !km[k] && (ks[k] || ki[k]);
                s_ld[k] = sv_n[k] && !(km[k] && ks[k]);
            end
        end

        always_ff @(posedge clk_i) begin
            for (int k = 0; k < NumStages; k++) begin
                if (!rst_ni || flush_i) begin
                    main_v[k] <= 1'b0;
                    skid_v[k] <= 1'b0;
                end else begin
                    main_v[k] <= mv_n[k];
                    skid_v[k] <= sv_n[k];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            for (int k = 0; k < NumStages; k++) begin
                if (m_ld[k] && !flush_i) begin
                    main_d[k] <= ks[k] ? skid_d[k] : up_d[k];
                    main_t[k] <= ks[k] ? skid_t[k] : up_t[k];
                end
                if (s_ld[k] && !flush_i) begin
                    skid_d[k] <= up_d[k];
                    skid_t[k] <= up_t[k];
                end
            end
        end

        assign in_ready_o  = !skid_v[0];
        assign out_valid_o = out_v[NumStages-1];
        assign data_o      = out_d[NumStages-1];
        assign tag_o       = out_t[NumStages-1];
        assign occupancy_o = OccW'($countones(main_v) + $countones(skid_v));
        assign busy_o      = in_valid_i || (|main_v) || (|skid_v);
    end

endmodule
